// File: rtl/i2c_seq_pkg.sv
// Shared types and helpers for the I2C init-table sequencer.
package i2c_seq_pkg;

    localparam int unsigned SADR_W  = 7;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLoad,
        StGap,
        StIssue,
        StWaitDone,
        StCheck,
        StGroupGap,
        StFin,
        StErr
    } seq_state_e;

    // A ROM word is {reg_addr, reg_data}; reg_data occupies the low bits.
    function automatic int unsigned rom_addr_lsb(int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned rom_addr_msb(int unsigned reg_aw, int unsigned data_w);
        return reg_aw + data_w - 1;
    endfunction

    // Bits needed to hold values 0..max(a,b)-1, never less than one bit.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : int'($clog2(m));
    endfunction

endpackage

// File: rtl/i2c_seq_ctrl_if.sv
// ROM and I2C-master-side signals of the init sequencer.
// The master modport is the sequencer's view; slave is the ROM/master-wrapper side.
interface i2c_seq_ctrl_if #(
    parameter int unsigned REG_AW = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROM_AW = 9
);
    logic [ROM_AW-1:0]        rom_addr;
    logic [REG_AW+DATA_W-1:0] rom_data;
    logic [6:0]               m_sadr;
    logic [REG_AW-1:0]        m_addr;
    logic [DATA_W-1:0]        m_data;
    logic                     m_start;
    logic                     m_ready;
    logic                     m_done;
    logic                     m_nack;

    modport master (
        output rom_addr,
        input  rom_data,
        output m_sadr,
        output m_addr,
        output m_data,
        output m_start,
        input  m_ready,
        input  m_done,
        input  m_nack
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  m_sadr,
        input  m_addr,
        input  m_data,
        input  m_start,
        output m_ready,
        output m_done,
        output m_nack
    );
endinterface

// File: rtl/seq_delay_counter.sv
// Loadable down-counter used for both the per-write gap and the group gap.
// Holds at zero rather than wrapping.
module seq_delay_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [Width-1:0] load_val,
    output logic             zero
);

    logic [Width-1:0] count_q;

    // Load has priority over counting; decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Zero flag straight from the count register.
    always_comb begin
        zero = (count_q == '0);
    end

endmodule

// File: rtl/i2c_seq_ctrl.sv
// I2C init sequencer: walks a {reg_addr, reg_data} table in a synchronous ROM and
// issues one master write per entry, with per-write and per-group idle gaps,
// bounded NACK retry, sticky error and abort.
module i2c_seq_ctrl
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0]  SADR        = 7'b0010000,
    parameter int unsigned REG_AW      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ROM_AW      = 9,
    parameter int unsigned NUM_ENTRIES = 386,
    parameter int unsigned GROUP_SIZE  = 4,
    parameter int unsigned GAP_WAIT    = 4,
    parameter int unsigned GROUP_WAIT  = 24'h493E00,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_top,
    input  logic              abort,
    i2c_seq_ctrl_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] entry_idx
);

    localparam int unsigned CntW    = cnt_width(GAP_WAIT, GROUP_WAIT);
    localparam int unsigned GroupW  = cnt_width(GROUP_SIZE, 1);
    localparam int unsigned AddrMsb = rom_addr_msb(REG_AW, DATA_W);
    localparam int unsigned AddrLsb = rom_addr_lsb(DATA_W);

    localparam logic [CntW-1:0]    GapLoad   = CntW'(GAP_WAIT - 1);
    localparam logic [CntW-1:0]    GroupLoad = CntW'(GROUP_WAIT - 1);
    localparam logic [ROM_AW-1:0]  LastIdx   = ROM_AW'(NUM_ENTRIES - 1);
    localparam logic [GroupW-1:0]  GroupLast = GroupW'(GROUP_SIZE - 1);
    localparam logic [RETRY_W-1:0] MaxRetry  = RETRY_W'(MAX_RETRY);

    seq_state_e          state_q, state_d;
    logic [ROM_AW-1:0]   entry_idx_q, entry_idx_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [GroupW-1:0]   group_q, group_d;
    logic [REG_AW-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                error_q, error_d;
    logic                abort_q, abort_d;

    logic                issue_start;
    logic                dly_load;
    logic                dly_en;
    logic [CntW-1:0]     dly_val;
    logic                dly_zero;

    seq_delay_counter #(
        .Width (CntW)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (dly_load),
        .en       (dly_en),
        .load_val (dly_val),
        .zero     (dly_zero)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            entry_idx_q <= '0;
            retry_q     <= '0;
            group_q     <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            error_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_idx_q <= entry_idx_d;
            retry_q     <= retry_d;
            group_q     <= group_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            error_q     <= error_d;
            abort_q     <= abort_d;
        end
    end

    // Next-state logic, counter control and the master start strobe.
    always_comb begin
        state_d     = state_q;
        entry_idx_d = entry_idx_q;
        retry_d     = retry_q;
        group_d     = group_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        error_d     = error_q;
        abort_d     = abort_q;
        issue_start = 1'b0;
        dly_load    = 1'b0;
        dly_en      = 1'b0;
        dly_val     = '0;

        // An abort mid-transaction must wait for the master to finish, so
        // WAIT_DONE handles it itself; everywhere else it is immediate.
        if (abort && (state_q != StIdle) && (state_q != StWaitDone)) begin
            state_d = StIdle;
            abort_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_top && !abort) begin
                        state_d     = StFetch;
                        error_d     = 1'b0;
                        entry_idx_d = '0;
                        retry_d     = '0;
                        group_d     = '0;
                        abort_d     = 1'b0;
                    end
                end
                StFetch: begin
                    state_d = StLoad;
                end
                StLoad: begin
                    m_addr_d = bus.rom_data[AddrMsb:AddrLsb];
                    m_data_d = bus.rom_data[DATA_W-1:0];
                    dly_load = 1'b1;
                    dly_val  = GapLoad;
                    state_d  = StGap;
                end
                StGap: begin
                    if (dly_zero) begin
                        state_d = StIssue;
                    end else begin
                        dly_en = 1'b1;
                    end
                end
                StIssue: begin
                    if (bus.m_ready) begin
                        issue_start = 1'b1;
                        state_d     = StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (abort) begin
                        abort_d = 1'b1;
                    end
                    if (bus.m_done) begin
                        abort_d = 1'b0;
                        if (abort || abort_q) begin
                            state_d = StIdle;
                        end else if (!bus.m_nack) begin
                            state_d = StCheck;
                        end else if (retry_q < MaxRetry) begin
                            // Re-issue the same write; m_addr/m_data are kept.
                            retry_d  = retry_q + 1'b1;
                            dly_load = 1'b1;
                            dly_val  = GapLoad;
                            state_d  = StGap;
                        end else begin
                            error_d = 1'b1;
                            state_d = StErr;
                        end
                    end
                end
                StCheck: begin
                    retry_d = '0;
                    if (entry_idx_q == LastIdx) begin
                        state_d = StFin;
                    end else begin
                        entry_idx_d = entry_idx_q + 1'b1;
                        if (group_q == GroupLast) begin
                            group_d  = '0;
                            dly_load = 1'b1;
                            dly_val  = GroupLoad;
                            state_d  = StGroupGap;
                        end else begin
                            group_d = group_q + 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
                StGroupGap: begin
                    if (dly_zero) begin
                        state_d = StFetch;
                    end else begin
                        dly_en = 1'b1;
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                StErr: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output drive; ROM address follows the entry index directly.
    always_comb begin
        bus.rom_addr = entry_idx_q;
        bus.m_sadr   = SADR;
        bus.m_addr   = m_addr_q;
        bus.m_data   = m_data_q;
        bus.m_start  = issue_start;
        busy         = (state_q != StIdle) && (state_q != StFin) && (state_q != StErr);
        done         = (state_q == StFin) && !abort;
        error        = error_q;
        entry_idx    = entry_idx_q;
    end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Directed bench for i2c_seq_ctrl with an 8-entry table, groups of 4,
// 4-cycle write gap, 20-cycle group gap and up to 3 retries.
module tb_i2c_seq_ctrl;

    localparam int unsigned NumEntries = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_top;
    logic       abort;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] entry_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    i2c_seq_ctrl_if #(.REG_AW(16), .DATA_W(8), .ROM_AW(4)) bus ();

    i2c_seq_ctrl #(
        .SADR        (7'b0010000),
        .REG_AW      (16),
        .DATA_W      (8),
        .ROM_AW      (4),
        .NUM_ENTRIES (NumEntries),
        .GROUP_SIZE  (4),
        .GAP_WAIT    (4),
        .GROUP_WAIT  (20),
        .MAX_RETRY   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_top (start_top),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .entry_idx (entry_idx)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Table contents: entry i = {16'h1000 + 16'h0111*i, 8'hA0 + i}.
    function automatic logic [23:0] rom_word(int i);
        logic [15:0] a;
        logic [7:0]  d;
        a = 16'(16'h1000 + 16'h0111 * i);
        d = 8'(8'hA0 + i);
        return {a, d};
    endfunction

    // Synchronous ROM with one cycle of read latency.
    initial begin
        bus.rom_data = '0;
        forever begin
            @(posedge clk);
            bus.rom_data <= rom_word(int'(bus.rom_addr));
        end
    end

    // Master model: answers every start two cycles later; logs starts and done pulses.
    int          resp_cnt = 0;
    logic        resp_nack = 1'b0;
    int          nack_plan [NumEntries] = '{default: 0};
    int          hold_idx = -1;
    int          st_cyc [$];
    logic [15:0] st_addr [$];
    logic [7:0]  st_data [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;

    initial begin
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.m_done = 1'b0;
            bus.m_nack = 1'b0;
            if (reset) begin
                resp_cnt = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.m_done = 1'b1;
                    bus.m_nack = resp_nack;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (bus.m_start) begin
                st_cyc.push_back(cyc);
                st_addr.push_back(bus.m_addr);
                st_data.push_back(bus.m_data);
                if (int'(entry_idx) != hold_idx) begin
                    resp_cnt  = 2;
                    resp_nack = 1'b0;
                    if (nack_plan[entry_idx] > 0) begin
                        nack_plan[entry_idx]--;
                        resp_nack = 1'b1;
                    end
                end
            end
        end
    end

    task automatic clear_log();
        st_cyc.delete();
        st_addr.delete();
        st_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        start_top = 1'b1;
        s = cyc;
        @(negedge clk);
        start_top = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    task automatic wait_starts(input int n, input int bound);
        int k = 0;
        while (st_cyc.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (st_cyc.size() < n) begin
            n_bad++;
            $display("FAIL start_timeout: got %0d starts, need %0d", st_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_top = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
        n_cmp++; if (entry_idx !== 4'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", entry_idx); end
        n_cmp++; if (bus.rom_addr !== 4'd0) begin n_bad++; $display("FAIL rst_rom_addr: got %0d want 0", bus.rom_addr); end
        n_cmp++; if (bus.m_addr !== 16'h0) begin n_bad++; $display("FAIL rst_m_addr: got %h want 0", bus.m_addr); end
        n_cmp++; if (bus.m_data !== 8'h0) begin n_bad++; $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
        n_cmp++; if (bus.m_start !== 1'b0) begin n_bad++; $display("FAIL rst_m_start: got %b want 0", bus.m_start); end
        n_cmp++; if (bus.m_sadr !== 7'h10) begin n_bad++; $display("FAIL rst_sadr: got %h want 10", bus.m_sadr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        int s;
        int exp_gap [7] = '{10, 10, 10, 30, 10, 10, 10};
        clear_log();
        pulse_start(s);
        repeat (30) @(negedge clk);
        start_top = 1'b1;  // must be ignored while busy
        @(negedge clk);
        start_top = 1'b0;
        wait_done(400);
        repeat (20) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 8) begin n_bad++; $display("FAIL seq_count: got %0d want 8", st_cyc.size()); end
        if (st_cyc.size() == 8) begin
            n_cmp++;
            if (st_cyc[0] - s !== 7) begin n_bad++; $display("FAIL seq_first_lat: got %0d want 7", st_cyc[0] - s); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if ({st_addr[k], st_data[k]} !== rom_word(k)) begin
                    n_bad++;
                    $display("FAIL seq_word%0d: got %h want %h", k, {st_addr[k], st_data[k]}, rom_word(k));
                end
            end
            for (int k = 0; k < 7; k++) begin
                n_cmp++;
                if (st_cyc[k+1] - st_cyc[k] !== exp_gap[k]) begin
                    n_bad++;
                    $display("FAIL seq_gap%0d: got %0d want %0d", k, st_cyc[k+1] - st_cyc[k], exp_gap[k]);
                end
            end
            n_cmp++;
            if (done_cyc - st_cyc[7] !== 4) begin n_bad++; $display("FAIL seq_done_lat: got %0d want 4", done_cyc - st_cyc[7]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL seq_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (done_busy !== 1'b0) begin n_bad++; $display("FAIL seq_busy_at_done: got %b want 0", done_busy); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL seq_error: got %b want 0", error); end
    endtask

    task automatic test_retry();
        int s;
        int exp_idx [10] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
        clear_log();
        nack_plan[2] = 2;
        pulse_start(s);
        wait_done(500);
        repeat (5) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 10) begin n_bad++; $display("FAIL retry_count: got %0d want 10", st_cyc.size()); end
        if (st_cyc.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                n_cmp++;
                if ({st_addr[k], st_data[k]} !== rom_word(exp_idx[k])) begin
                    n_bad++;
                    $display("FAIL retry_word%0d: got %h want %h", k, {st_addr[k], st_data[k]},
                             rom_word(exp_idx[k]));
                end
            end
            n_cmp++;
            if (st_cyc[3] - st_cyc[2] !== 7) begin n_bad++; $display("FAIL retry_gap1: got %0d want 7", st_cyc[3] - st_cyc[2]); end
            n_cmp++;
            if (st_cyc[4] - st_cyc[3] !== 7) begin n_bad++; $display("FAIL retry_gap2: got %0d want 7", st_cyc[4] - st_cyc[3]); end
        end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL retry_error: got %b want 0", error); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL retry_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_nack_limit();
        int s;
        clear_log();
        nack_plan[1] = 4;
        pulse_start(s);
        wait_starts(5, 200);
        repeat (8) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 5) begin n_bad++; $display("FAIL lim_count: got %0d want 5", st_cyc.size()); end
        if (st_cyc.size() >= 5) begin
            n_cmp++;
            if ({st_addr[4], st_data[4]} !== rom_word(1)) begin
                n_bad++;
                $display("FAIL lim_word: got %h want %h", {st_addr[4], st_data[4]}, rom_word(1));
            end
        end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL lim_error: got %b want 1", error); end
        n_cmp++; if (entry_idx !== 4'd1) begin n_bad++; $display("FAIL lim_idx: got %0d want 1", entry_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lim_busy: got %b want 0", busy); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL lim_done: got %0d want 0", done_cnt); end
        pulse_start(s);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL lim_err_clear: got %b want 0", error); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lim_restart_busy: got %b want 1", busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lim_abort_fetch: got %b want 0", busy); end
        repeat (10) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 5) begin n_bad++; $display("FAIL lim_no_start: got %0d want 5", st_cyc.size()); end
    endtask

    task automatic test_abort_gap();
        int s;
        clear_log();
        pulse_start(s);
        repeat (3) @(negedge clk);  // second GAP cycle
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abg_busy: got %b want 0", busy); end
        repeat (15) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 0) begin n_bad++; $display("FAIL abg_start: got %0d want 0", st_cyc.size()); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abg_done: got %0d want 0", done_cnt); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL abg_error: got %b want 0", error); end
        @(negedge clk);
        start_top = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start_top = 1'b0;
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abg_both_busy: got %b want 0", busy); end
        repeat (12) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 0) begin n_bad++; $display("FAIL abg_both_start: got %0d want 0", st_cyc.size()); end
    endtask

    task automatic test_abort_wait();
        int s;
        clear_log();
        nack_plan[0] = 1;
        pulse_start(s);
        repeat (7) @(negedge clk);  // first WAIT_DONE cycle
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abw_hold: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abw_idle: got %b want 0", busy); end
        repeat (15) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 1) begin n_bad++; $display("FAIL abw_retry: got %0d starts want 1", st_cyc.size()); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abw_done: got %0d want 0", done_cnt); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL abw_error: got %b want 0", error); end
    endtask

    task automatic test_reset_mid();
        int s;
        clear_log();
        hold_idx = 1;
        pulse_start(s);
        wait_starts(2, 100);
        repeat (2) @(negedge clk);
        n_cmp++; if (entry_idx !== 4'd1) begin n_bad++; $display("FAIL rmid_pre_idx: got %0d want 1", entry_idx); end
        n_cmp++; if (bus.m_addr !== 16'h1111) begin n_bad++; $display("FAIL rmid_pre_addr: got %h want 1111", bus.m_addr); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (entry_idx !== 4'd0) begin n_bad++; $display("FAIL rmid_idx: got %0d want 0", entry_idx); end
        n_cmp++; if (bus.m_addr !== 16'h0) begin n_bad++; $display("FAIL rmid_addr: got %h want 0", bus.m_addr); end
        n_cmp++; if (bus.m_data !== 8'h0) begin n_bad++; $display("FAIL rmid_data: got %h want 0", bus.m_data); end
        n_cmp++; if (bus.m_start !== 1'b0) begin n_bad++; $display("FAIL rmid_start: got %b want 0", bus.m_start); end
        @(negedge clk);
        reset = 1'b0;
        hold_idx = -1;
        clear_log();
        pulse_start(s);
        wait_done(400);
        repeat (3) @(negedge clk);
        n_cmp++; if (st_cyc.size() !== 8) begin n_bad++; $display("FAIL rmid_count: got %0d want 8", st_cyc.size()); end
        if (st_cyc.size() > 0) begin
            n_cmp++;
            if ({st_addr[0], st_data[0]} !== rom_word(0)) begin
                n_bad++;
                $display("FAIL rmid_first: got %h want %h", {st_addr[0], st_data[0]}, rom_word(0));
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rmid_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_retry();
        test_nack_limit();
        test_abort_gap();
        test_abort_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_seq_ctrl.md
Name: i2c_seq_ctrl

Overview:
Parametrised successor to the fixed-count I2C init sequencer. Walks a register-write table in an external synchronous ROM and issues one I2C master write per entry. Inserts a programmable gap between writes and a longer gap after each group of entries. Adds NACK retry with a limit, a sticky error flag, abort, and status outputs; sits between the init ROM and the I2C master wrapper.

Parameters:
SADR, 7'b0010000, 7-bit slave address forwarded to master
REG_AW, 16, register address width in bits (8 or 16)
DATA_W, 8, register data width in bits
ROM_AW, 9, ROM address width
NUM_ENTRIES, 386, table entries to issue (1..2**ROM_AW)
GROUP_SIZE, 4, entries per group before the group gap (>=1)
GAP_WAIT, 4, idle cycles before each write (>=1)
GROUP_WAIT, 24'h493E00, idle cycles after each completed group (>=1)
MAX_RETRY, 3, re-issues allowed per entry after NACK (0..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start_top  in  1  level/pulse; begins the sequence when sampled high in IDLE
abort  in  1  stop the sequence and return to IDLE
rom_addr  out  ROM_AW  table index to ROM
rom_data  in  REG_AW+DATA_W  {reg_addr, reg_data}, valid 1 cycle after rom_addr
m_sadr  out  7  constant SADR
m_addr  out  REG_AW  register address to master
m_data  out  DATA_W  register data to master
m_start  out  1  one-cycle start pulse to master
m_ready  in  1  master can accept a start
m_done  in  1  one-cycle pulse: transaction finished
m_nack  in  1  valid with m_done; 1 = slave NACKed
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on completing all entries
error  out  1  sticky: retry limit exhausted
entry_idx  out  ROM_AW  index currently being issued

Behaviour:
- Reset (async): state IDLE; rom_addr, entry_idx, m_addr, m_data, and the retry, group and delay counters all 0; m_start, busy, done, error 0.
- States: IDLE, FETCH, LOAD, GAP, ISSUE, WAIT_DONE, CHECK, GROUP_GAP, FIN, ERR.
- IDLE: on start_top go to FETCH. Clear error, entry_idx, retry and group counters; set busy.
- FETCH: rom_addr = entry_idx. Next cycle go to LOAD (1-cycle ROM latency).
- LOAD: latch rom_data[REG_AW+DATA_W-1:DATA_W] into m_addr and rom_data[DATA_W-1:0] into m_data. Load the delay counter with GAP_WAIT-1. Go to GAP.
- GAP: decrement to 0, then go to ISSUE. Exactly GAP_WAIT cycles are spent in GAP.
- ISSUE: hold until m_ready=1. In that cycle m_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for m_done.
  - m_done with m_nack=0: go to CHECK.
  - m_done with m_nack=1 and retry<MAX_RETRY: retry++, go to GAP (reload GAP_WAIT-1; m_addr/m_data are not re-fetched).
  - m_done with m_nack=1 and retry==MAX_RETRY: go to ERR.
- CHECK: retry cleared.
  - If entry_idx==NUM_ENTRIES-1: go to FIN.
  - Otherwise entry_idx++ and group++.
  - If group reaches GROUP_SIZE: group cleared, delay counter loaded with GROUP_WAIT-1, go to GROUP_GAP. Otherwise go to FETCH.
- GROUP_GAP: count down, then go to FETCH. The final entry never incurs a group gap.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- ERR: error=1 (sticky), busy=0, go to IDLE. entry_idx holds the failing index until the next start.
- abort in any state except WAIT_DONE or IDLE: go to IDLE next cycle, m_start=0, busy=0. No done pulse, error unchanged.
- abort during WAIT_DONE: latched. On m_done go to IDLE regardless of m_nack; no retry, no done.
- start_top while busy: ignored.
- abort and start_top together in IDLE: abort wins, stay IDLE.
- m_done outside WAIT_DONE: ignored.
- Delay counter width: clog2 of max(GAP_WAIT, GROUP_WAIT). No wrap; it saturates at 0.
- entry_idx never exceeds NUM_ENTRIES-1.

Decomposition:
- Package i2c_seq_pkg: state encoding constants, the ROM field-split helper constants, and clog2 width function.
- One sub-module, seq_delay_counter: loadable down-counter with load, enable, zero flag and async reset. Shared by GAP and GROUP_GAP.

Test Plan:
- NUM_ENTRIES=3, GROUP_SIZE=4, GAP_WAIT=4, master always ACKs -> 3 m_start pulses with m_addr/m_data matching ROM entries 0..2. Each pulse comes >=4 cycles after LOAD. done pulses once; busy falls the same cycle.
- NUM_ENTRIES=8, GROUP_SIZE=4, GROUP_WAIT=20 -> exactly one 20-cycle group gap, between entries 3 and 4. None after entry 7.
- NACK on entry 2 twice then ACK, MAX_RETRY=3 -> 3 starts for entry 2 with the same addr/data. Sequence completes; error=0.
- NACK on entry 1 four times, MAX_RETRY=3 -> 4 starts, then error=1, entry_idx=1, busy=0, no done. A new start_top clears error.
- abort during GAP -> IDLE next cycle with no m_start. abort during WAIT_DONE -> IDLE only after m_done; no retry even if m_nack=1.
- reset asserted mid WAIT_DONE -> all outputs 0 immediately (async). After release, start_top restarts from entry 0.
